// File: rtl/sccb_pkg.sv
// Shared SCCB master types: FSM states, table sentinel, COM7 address and phase byte select.
// No timing or backpressure of its own; pure declarations.
package sccb_pkg;

  typedef enum logic [2:0] {
    S_POWERUP,
    S_IDLE,
    S_LOAD,
    S_START,
    S_SEND,
    S_STOP,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [15:0] SENTINEL          = 16'hFFFF;
  localparam logic [7:0]  COM7_ADDR         = 8'h12;
  localparam logic [7:0]  DEFAULT_DEVICE_ID = 8'h42;

  function automatic logic [7:0] phase_byte(input logic [1:0] ph, input logic [7:0] id,
                                            input logic [7:0] rg, input logic [7:0] vl);
    case (ph)
      2'd0:    phase_byte = id;
      2'd1:    phase_byte = rg;
      default: phase_byte = vl;
    endcase
  endfunction

endpackage

// File: rtl/ov7670_config_rom.sv
// OV7670 register/value table, {reg,val} per entry, terminated by the 16'hFFFF sentinel.
// One-cycle read latency; always ready, no backpressure.
module ov7670_config_rom
  import sccb_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [15:0]       o_data
);

  logic [15:0] r_data;
  logic [15:0] w_rom;

  always_comb begin
    w_rom = SENTINEL;
    case (int'(i_addr))
      0:       w_rom = 16'h1280;
      1:       w_rom = 16'h1200;
      2:       w_rom = 16'h0C04;
      3:       w_rom = 16'h3E1A;
      4:       w_rom = 16'h703A;
      5:       w_rom = 16'h7135;
      6:       w_rom = 16'h7222;
      7:       w_rom = 16'h73F2;
      8:       w_rom = 16'hA202;
      default: w_rom = SENTINEL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    r_data <= w_rom;
  end

  assign o_data = r_data;

endmodule

// File: rtl/sccb_config_master.sv
// Walks the OV7670 config table after power-up, one 3-phase SCCB write per entry; start reruns it when idle/done.
// Bus changes only on quarter-bit ticks; start is ignored while busy. SCCB_SOFTRESET_WAIT_EN extends GAP after a COM7 reset.
module sccb_config_master
  import sccb_pkg::*;
#(
  parameter int          CLK_FREQ       = 25000000,
  parameter int          SCCB_FREQ      = 100000,
  parameter logic [7:0]  DEVICE_ID      = DEFAULT_DEVICE_ID,
  parameter int          ROM_ADDR_WIDTH = 8,
  parameter int          POWERUP_CYCLES = 25000
) (
  input  logic                      clk_25,
  input  logic                      reset_n,
  input  logic                      start,
  output logic                      sio_c,
  output logic                      sio_d_out,
  output logic                      sio_d_oe,
  output logic                      busy,
  output logic                      done,
  output logic [ROM_ADDR_WIDTH-1:0] rom_index
);

  localparam int                        QTR     = CLK_FREQ / (4 * SCCB_FREQ);
  localparam logic [31:0]               QTR_M1  = 32'(QTR - 1);
  localparam logic [31:0]               PWR_M1  = 32'(POWERUP_CYCLES - 1);
  localparam logic [ROM_ADDR_WIDTH-1:0] IDX_ONE = ROM_ADDR_WIDTH'(1);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [31:0]               r_qcnt;
  logic [31:0]               r_wcnt;
  logic [1:0]                r_q;
  logic [3:0]                r_bit;
  logic [1:0]                r_phase;
  logic                      r_lwait;
  logic [ROM_ADDR_WIDTH-1:0] r_rom_index;
  logic [7:0]                r_reg;
  logic [7:0]                r_val;
  logic                      r_busy;
  logic                      r_done;
`ifdef SCCB_SOFTRESET_WAIT_EN
  logic                      r_xwait;
  logic                      w_com7_rst;
`endif

  logic        w_tick;
  logic [15:0] w_rom_data;
  logic [7:0]  w_byte;
  logic [7:0]  w_byte_sh;
  logic        w_sio_c;
  logic        w_sio_d;
  logic        w_sio_oe;

  ov7670_config_rom #(
    .ADDR_W (ROM_ADDR_WIDTH)
  ) u_rom (
    .i_clk  (clk_25),
    .i_addr (r_rom_index),
    .o_data (w_rom_data)
  );

  assign w_tick    = (r_qcnt == QTR_M1);
  assign w_byte    = phase_byte(r_phase, DEVICE_ID, r_reg, r_val);
  assign w_byte_sh = w_byte << r_bit[2:0];
`ifdef SCCB_SOFTRESET_WAIT_EN
  assign w_com7_rst = (r_reg == COM7_ADDR) && r_val[7];
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_POWERUP: if (r_wcnt == PWR_M1) w_state_nxt = S_LOAD;
      S_IDLE:    if (start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        // ROM output is only valid on the second LOAD cycle
        if (&r_rom_index) w_state_nxt = S_DONE;
        else if (r_lwait) w_state_nxt = (w_rom_data == SENTINEL) ? S_DONE : S_START;
      end
      S_START:   if (w_tick && (r_q == 2'd1)) w_state_nxt = S_SEND;
      S_SEND: begin
        if (w_tick && (r_q == 2'd3) && (r_bit == 4'd8) && (r_phase == 2'd2))
          w_state_nxt = S_STOP;
      end
      S_STOP:    if (w_tick && (r_q == 2'd2)) w_state_nxt = S_GAP;
      S_GAP: begin
`ifdef SCCB_SOFTRESET_WAIT_EN
        if (r_xwait) begin
          if (r_wcnt == PWR_M1) w_state_nxt = S_LOAD;
        end else if (w_tick && (r_q == 2'd3) && !w_com7_rst) begin
          w_state_nxt = S_LOAD;
        end
`else
        if (w_tick && (r_q == 2'd3)) w_state_nxt = S_LOAD;
`endif
      end
      S_DONE:    if (start) w_state_nxt = S_LOAD;
      default:   w_state_nxt = S_POWERUP;
    endcase
  end

  always_comb begin
    w_sio_c  = 1'b1;
    w_sio_d  = 1'b1;
    w_sio_oe = 1'b1;
    case (r_state)
      S_START: w_sio_d = (r_q == 2'd0);
      S_SEND: begin
        w_sio_c = r_q[1];
        if (r_bit == 4'd8) w_sio_oe = 1'b0;
        else               w_sio_d  = w_byte_sh[7];
      end
      S_STOP: begin
        w_sio_c = (r_q != 2'd0);
        w_sio_d = (r_q == 2'd2);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_25 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_POWERUP;
      r_qcnt      <= '0;
      r_wcnt      <= '0;
      r_q         <= '0;
      r_bit       <= '0;
      r_phase     <= '0;
      r_lwait     <= 1'b0;
      r_rom_index <= '0;
      r_reg       <= '0;
      r_val       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef SCCB_SOFTRESET_WAIT_EN
      r_xwait     <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      r_done  <= (w_state_nxt == S_DONE);
      if (w_state_nxt != r_state) begin
        r_qcnt  <= '0;
        r_q     <= '0;
        r_wcnt  <= '0;
        r_lwait <= 1'b0;
`ifdef SCCB_SOFTRESET_WAIT_EN
        r_xwait <= 1'b0;
`endif
        if (w_state_nxt == S_LOAD) begin
          if (r_state == S_GAP)           r_rom_index <= r_rom_index + IDX_ONE;
          else if (r_state != S_POWERUP)  r_rom_index <= '0;
        end
        if (w_state_nxt == S_START) begin
          r_reg   <= w_rom_data[15:8];
          r_val   <= w_rom_data[7:0];
          r_bit   <= '0;
          r_phase <= '0;
        end
      end else begin
        r_qcnt <= w_tick ? '0 : r_qcnt + 32'd1;
        if (w_tick) r_q <= r_q + 2'd1;
        case (r_state)
          S_POWERUP: r_wcnt  <= r_wcnt + 32'd1;
          S_LOAD:    r_lwait <= 1'b1;
          S_SEND: begin
            if (w_tick && (r_q == 2'd3)) begin
              if (r_bit == 4'd8) begin
                r_bit   <= '0;
                r_phase <= r_phase + 2'd1;
              end else begin
                r_bit <= r_bit + 4'd1;
              end
            end
          end
`ifdef SCCB_SOFTRESET_WAIT_EN
          S_GAP: begin
            if (r_xwait)                                        r_wcnt  <= r_wcnt + 32'd1;
            else if (w_tick && (r_q == 2'd3) && w_com7_rst)     r_xwait <= 1'b1;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign sio_c     = w_sio_c;
  assign sio_d_out = w_sio_d;
  assign sio_d_oe  = w_sio_oe;
  assign busy      = r_busy;
  assign done      = r_done;
  assign rom_index = r_rom_index;

endmodule

// File: tb/tb_sccb_config_master.sv
// Directed bench for sccb_config_master: decodes SCCB frames from the pins and checks table order and timing.
module tb_sccb_config_master;

  localparam int QTR = 4;
  localparam int P   = 300;
  localparam int TMO = 600 * QTR + 2 * P;
`ifdef SCCB_SOFTRESET_WAIT_EN
  localparam int XW  = P;
`else
  localparam int XW  = 0;
`endif

  logic       clk_25;
  logic       reset_n;
  logic       start;
  logic       sio_c;
  logic       sio_d_out;
  logic       sio_d_oe;
  logic       busy;
  logic       done;
  logic [7:0] rom_index;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [15:0] tbl [9];

  sccb_config_master #(
    .CLK_FREQ       (25000000),
    .SCCB_FREQ      (1562500),
    .DEVICE_ID      (8'h42),
    .ROM_ADDR_WIDTH (8),
    .POWERUP_CYCLES (P)
  ) dut (
    .clk_25    (clk_25),
    .reset_n   (reset_n),
    .start     (start),
    .sio_c     (sio_c),
    .sio_d_out (sio_d_out),
    .sio_d_oe  (sio_d_oe),
    .busy      (busy),
    .done      (done),
    .rom_index (rom_index)
  );

  initial clk_25 = 1'b0;
  always #20 clk_25 = ~clk_25;
  always @(posedge clk_25) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h (%0d) expected 0x%0h (%0d)", tag, obs, obs, exp, exp);
    end
  endtask

  // Waits for a start condition, collects 27 bits on sio_c rising edges, then waits for the stop.
  task automatic get_frame(output logic [7:0] b0, output logic [7:0] b1, output logic [7:0] b2,
                           output int oe_bad, output int pre_bad, output int t_start,
                           output int t_stop, output int ok);
    logic        pc, pd;
    logic [26:0] sh;
    int          bits;
    ok = 0; oe_bad = 0; pre_bad = 0; bits = 0; sh = '0; t_start = -1; t_stop = -1;
    pc = sio_c; pd = sio_d_out;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk_25);
      if (t_start < 0) begin
        if (!sio_c) pre_bad = 1;
        if (pc && sio_c && pd && !sio_d_out) t_start = cyc;
      end else if (bits < 27) begin
        if (!pc && sio_c) begin
          sh = {sh[25:0], sio_d_out};
          if (((bits % 9) == 8) == sio_d_oe) oe_bad++;
          bits++;
        end
      end else if (pc && sio_c && !pd && sio_d_out) begin
        t_stop = cyc;
        ok = 1;
        break;
      end
      pc = sio_c; pd = sio_d_out;
    end
    b0 = sh[26:19]; b1 = sh[17:10]; b2 = sh[8:1];
  endtask

  initial begin
    logic [7:0] b0, b1, b2;
    int oe_bad, pre_bad, t_start, t_stop, ok, rel, prev_stop, lowcnt;
    tbl[0] = 16'h1280; tbl[1] = 16'h1200; tbl[2] = 16'h0C04;
    tbl[3] = 16'h3E1A; tbl[4] = 16'h703A; tbl[5] = 16'h7135;
    tbl[6] = 16'h7222; tbl[7] = 16'h73F2; tbl[8] = 16'hA202;
    reset_n = 1'b0;
    start   = 1'b0;

    repeat (10) @(negedge clk_25);
    chk("rst_sio_c", 32'(sio_c), 1);
    chk("rst_sio_d", 32'(sio_d_out), 1);
    chk("rst_oe", 32'(sio_d_oe), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_idx", 32'(rom_index), 0);

    reset_n = 1'b1;
    rel = cyc;
    @(negedge clk_25);
    chk("busy_after_release", 32'(busy), 1);
    repeat (8) @(negedge clk_25);
    start = 1'b1;
    @(negedge clk_25);
    start = 1'b0;

    get_frame(b0, b1, b2, oe_bad, pre_bad, t_start, t_stop, ok);
    chk("f0_ok", 32'(ok), 1);
    chk("f0_no_early_scl", 32'(pre_bad), 0);
    chk("f0_start_time", 32'(t_start - rel), 32'(P + 2 + QTR));
    chk("f0_id", 32'(b0), 32'h42);
    chk("f0_reg", 32'(b1), 32'h12);
    chk("f0_val", 32'(b2), 32'h80);
    chk("f0_oe", 32'(oe_bad), 0);
    chk("f0_idx_at_stop", 32'(rom_index), 0);
    repeat (5 * QTR + XW - 1) @(negedge clk_25);
    chk("idx_before_gap_end", 32'(rom_index), 0);
    @(negedge clk_25);
    chk("idx_after_gap", 32'(rom_index), 1);
    prev_stop = t_stop;

    for (int e = 1; e < 9; e++) begin
      get_frame(b0, b1, b2, oe_bad, pre_bad, t_start, t_stop, ok);
      chk($sformatf("f%0d_ok", e), 32'(ok), 1);
      chk($sformatf("f%0d_gap", e), 32'(t_start - prev_stop), 32'(6 * QTR + 2 + ((e == 1) ? XW : 0)));
      chk($sformatf("f%0d_id", e), 32'(b0), 32'h42);
      chk($sformatf("f%0d_reg", e), 32'(b1), 32'(tbl[e][15:8]));
      chk($sformatf("f%0d_val", e), 32'(b2), 32'(tbl[e][7:0]));
      chk($sformatf("f%0d_oe", e), 32'(oe_bad), 0);
      prev_stop = t_stop;
    end

    for (int i = 0; i < 20 * QTR && !done; i++) @(negedge clk_25);
    chk("done_set", 32'(done), 1);
    chk("done_busy", 32'(busy), 0);
    chk("done_idx", 32'(rom_index), 9);
    lowcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_25);
      if (!sio_c) lowcnt++;
    end
    chk("done_bus_quiet", 32'(lowcnt), 0);

    start = 1'b1;
    @(negedge clk_25);
    start = 1'b0;
    chk("rerun_done_clr", 32'(done), 0);
    chk("rerun_busy", 32'(busy), 1);
    chk("rerun_idx", 32'(rom_index), 0);
    get_frame(b0, b1, b2, oe_bad, pre_bad, t_start, t_stop, ok);
    chk("r0_ok", 32'(ok), 1);
    chk("r0_reg", 32'(b1), 32'h12);
    chk("r0_val", 32'(b2), 32'h80);
    prev_stop = t_stop;

    @(negedge clk_25);
    start = 1'b1;
    @(negedge clk_25);
    start = 1'b0;
    get_frame(b0, b1, b2, oe_bad, pre_bad, t_start, t_stop, ok);
    chk("r1_ok", 32'(ok), 1);
    chk("r1_gap", 32'(t_start - prev_stop), 32'(6 * QTR + 2 + XW));
    chk("r1_reg", 32'(b1), 32'h12);
    chk("r1_val", 32'(b2), 32'h00);
    chk("r1_idx", 32'(rom_index), 1);

    repeat (6 * QTR + 2) @(negedge clk_25);
    chk("r2_start_scl", 32'(sio_c), 1);
    chk("r2_start_sda", 32'(sio_d_out), 0);
    repeat (37 * QTR + 1) @(negedge clk_25);
    chk("r2_ph1_scl_low", 32'(sio_c), 0);
    chk("r2_ph1_idx", 32'(rom_index), 2);
    #5 reset_n = 1'b0;
    #1;
    chk("async_rst_sio_c", 32'(sio_c), 1);
    chk("async_rst_sio_d", 32'(sio_d_out), 1);
    chk("async_rst_oe", 32'(sio_d_oe), 1);
    chk("async_rst_busy", 32'(busy), 0);
    chk("async_rst_idx", 32'(rom_index), 0);

    repeat (3) @(negedge clk_25);
    reset_n = 1'b1;
    rel = cyc;
    get_frame(b0, b1, b2, oe_bad, pre_bad, t_start, t_stop, ok);
    chk("post_rst_ok", 32'(ok), 1);
    chk("post_rst_start_time", 32'(t_start - rel), 32'(P + 2 + QTR));
    chk("post_rst_id", 32'(b0), 32'h42);
    chk("post_rst_reg", 32'(b1), 32'h12);
    chk("post_rst_val", 32'(b2), 32'h80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
